oled_i2c_sequencer: RTL and testbench

// Sequencer on the byte interface of the I2C byte master. After power-up it

---
 rtl/oled_i2c_sequencer_if.sv | 24 ++
 rtl/oled_i2c_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_oled_i2c_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_i2c_sequencer_if.sv
// Signal bundle between the OLED sequencer, the I2C byte master and the pixel client.
// The master modport is the sequencer's view; slave is the environment's view.
interface oled_i2c_sequencer_if;
  logic [7:0] i2c_data;
  logic       i2c_start;
  logic       i2c_last;
  logic       i2c_busy;
  logic       i2c_done;
  logic       pix_req;
  logic [2:0] pix_page;
  logic [6:0] pix_col;
  logic [7:0] pix_data;
  logic       pix_ack;

  modport master (
    output i2c_data, i2c_start, i2c_last, pix_ack,
    input  i2c_busy, i2c_done, pix_req, pix_page, pix_col, pix_data
  );

  modport slave (
    input  i2c_data, i2c_start, i2c_last, pix_ack,
    output i2c_busy, i2c_done, pix_req, pix_page, pix_col, pix_data
  );
endinterface

// File: rtl/oled_i2c_sequencer.sv
// Drives an I2C byte master: SSD1306 init stream after power-up, then
// single-byte page/column pixel writes framed as a command plus a data transaction.
module oled_i2c_sequencer #(
  parameter logic [6:0]  I2C_ADDR    = 7'h3C,
  parameter int unsigned PWRUP_CYC   = 1_000_000,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  oled_i2c_sequencer_if.master bus,
  output logic                 ready,
  output logic                 err
);

  localparam int PW_W = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
  localparam int TM_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW_W-1:0] PWR_LAST  = PW_W'(PWRUP_CYC - 1);
  localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      ADDR_BYTE = {I2C_ADDR, 1'b0};
  localparam logic [4:0]      INIT_LAST = 5'd26;
  localparam logic [4:0]      CMD_LAST  = 5'd4;
  localparam logic [4:0]      DATA_LAST = 5'd2;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_PIX_CMD,
    S_PIX_DATA
  } top_state_t;

  typedef enum logic [1:0] {
    B_LOAD,
    B_ISSUE,
    B_WAIT_DONE
  } byte_state_t;

  top_state_t      top_q, top_d;
  byte_state_t     byte_q, byte_d;
  logic [4:0]      idx_q, idx_d;
  logic [PW_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [TM_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]      page_q, page_d;
  logic [6:0]      col_q, col_d;
  logic [7:0]      pdata_q, pdata_d;
  logic [7:0]      data_q, data_d;
  logic            start_q, start_d;
  logic            last_q, last_d;
  logic            ack_q, ack_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic [7:0]      cur_byte;
  logic            cur_last;
  logic            in_xfer;
  logic            byte_done;
  logic            byte_tmo;

  function automatic logic [7:0] init_rom(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h02;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'hCF;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      5'd24:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte at position idx_q of the transaction the top FSM is currently in.
  always_comb begin
    cur_byte = 8'h00;
    cur_last = 1'b0;
    case (top_q)
      S_INIT: begin
        if (idx_q == 5'd0) begin
          cur_byte = ADDR_BYTE;
        end else if (idx_q == 5'd1) begin
          cur_byte = 8'h00;
        end else begin
          cur_byte = init_rom(idx_q - 5'd2);
        end
        cur_last = (idx_q == INIT_LAST);
      end
      S_PIX_CMD: begin
        case (idx_q)
          5'd0:    cur_byte = ADDR_BYTE;
          5'd1:    cur_byte = 8'h00;
          5'd2:    cur_byte = {5'b10110, page_q};
          5'd3:    cur_byte = {4'h0, col_q[3:0]};
          default: cur_byte = {5'b00010, col_q[6:4]};
        endcase
        cur_last = (idx_q == CMD_LAST);
      end
      S_PIX_DATA: begin
        case (idx_q)
          5'd0:    cur_byte = ADDR_BYTE;
          5'd1:    cur_byte = 8'h40;
          default: cur_byte = pdata_q;
        endcase
        cur_last = (idx_q == DATA_LAST);
      end
      default: ;
    endcase
  end

  assign in_xfer = (top_q == S_INIT) || (top_q == S_PIX_CMD) || (top_q == S_PIX_DATA);

  always_comb begin
    top_d     = top_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    pwr_cnt_d = pwr_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    page_d    = page_q;
    col_d     = col_q;
    pdata_d   = pdata_q;
    data_d    = data_q;
    start_d   = start_q;
    last_d    = last_q;
    ack_d     = 1'b0;
    ready_d   = ready_q;
    err_d     = err_q;
    byte_done = 1'b0;
    byte_tmo  = 1'b0;

    // Byte engine: data/last are loaded once and held until the byte completes.
    case (byte_q)
      B_LOAD: begin
        if (in_xfer) begin
          data_d    = cur_byte;
          last_d    = cur_last;
          start_d   = 1'b1;
          tmo_cnt_d = '0;
          byte_d    = B_ISSUE;
        end
      end
      B_ISSUE, B_WAIT_DONE: begin
        if ((byte_q == B_WAIT_DONE) && bus.i2c_done) begin
          byte_done = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          byte_tmo = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TM_W'(1);
          if ((byte_q == B_ISSUE) && bus.i2c_busy) begin
            start_d = 1'b0;
            byte_d  = B_WAIT_DONE;
          end
        end
        if (byte_done || byte_tmo) begin
          byte_d = B_LOAD;
        end
        if (byte_tmo) begin
          err_d   = 1'b1;
          start_d = 1'b0;
        end
      end
      default: byte_d = B_LOAD;
    endcase

    case (top_q)
      S_PWR_WAIT: begin
        if (pwr_cnt_q == PWR_LAST) begin
          pwr_cnt_d = '0;
          idx_d     = 5'd0;
          top_d     = S_INIT;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PW_W'(1);
        end
      end
      S_INIT: begin
        if (byte_tmo) begin
          idx_d = 5'd0;
        end else if (byte_done) begin
          if (last_q) begin
            idx_d   = 5'd0;
            ready_d = 1'b1;
            top_d   = S_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_IDLE: begin
        if (bus.pix_req) begin
          page_d  = bus.pix_page;
          col_d   = bus.pix_col;
          pdata_d = bus.pix_data;
          ready_d = 1'b0;
          idx_d   = 5'd0;
          top_d   = S_PIX_CMD;
        end
      end
      S_PIX_CMD: begin
        if (byte_tmo) begin
          idx_d   = 5'd0;
          ready_d = 1'b1;
          top_d   = S_IDLE;
        end else if (byte_done) begin
          if (last_q) begin
            idx_d = 5'd0;
            top_d = S_PIX_DATA;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_PIX_DATA: begin
        if (byte_tmo) begin
          idx_d   = 5'd0;
          ready_d = 1'b1;
          top_d   = S_IDLE;
        end else if (byte_done) begin
          if (last_q) begin
            idx_d   = 5'd0;
            ack_d   = 1'b1;
            ready_d = 1'b1;
            top_d   = S_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: top_d = S_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q     <= S_PWR_WAIT;
      byte_q    <= B_LOAD;
      idx_q     <= 5'd0;
      pwr_cnt_q <= '0;
      tmo_cnt_q <= '0;
      page_q    <= 3'd0;
      col_q     <= 7'd0;
      pdata_q   <= 8'h00;
      data_q    <= 8'h00;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      top_q     <= top_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      pwr_cnt_q <= pwr_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      page_q    <= page_d;
      col_q     <= col_d;
      pdata_q   <= pdata_d;
      data_q    <= data_d;
      start_q   <= start_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign bus.i2c_data  = data_q;
  assign bus.i2c_start = start_q;
  assign bus.i2c_last  = last_q;
  assign bus.pix_ack   = ack_q;
  assign ready         = ready_q;
  assign err           = err_q;

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Directed bench for oled_i2c_sequencer against a behavioural I2C byte master
// (busy 2 cycles after start, done 40 cycles later).
`timescale 1ns/1ps
module tb_oled_i2c_sequencer;
  localparam int PWRUP = 10;
  localparam int TMO   = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ready;
  logic err;

  oled_i2c_sequencer_if bus ();

  oled_i2c_sequencer #(
    .I2C_ADDR   (7'h3C),
    .PWRUP_CYC  (PWRUP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .ready(ready),
    .err  (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // master model state and observation log ({last, data} per started byte)
  logic [8:0] log_q[$];
  int  ms = 0;
  int  mcnt = 0;
  bit  no_done = 1'b0;
  int  start_cyc = 0;
  int  last_done_cyc = 0;
  int  ack_cnt = 0;

  logic [7:0] init_exp [0:26];
  logic [8:0] exp8 [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] get_log(input int i);
    if (i < log_q.size()) return {3'b000, log_q[i]};
    return 12'hFFF;
  endfunction

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < budget);
    check(tag, ready, 1);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.pix_ack && n < budget);
    check(tag, bus.pix_ack, 1);
  endtask

  task automatic wait_err(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!err && n < budget);
    check(tag, err, 1);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (log_q.size() < cnt && n < budget);
    check(tag, (log_q.size() >= cnt), 1);
  endtask

  task automatic check_init(input int base);
    for (int i = 0; i < 27; i++)
      check($sformatf("init_b%0d", i), get_log(base + i), {3'b000, (i == 26), init_exp[i]});
  endtask

  task automatic check_pix(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), get_log(base + i), {3'b000, exp8[i]});
  endtask

  // Behavioural byte master, driven on the falling edge.
  initial begin
    bus.i2c_busy = 1'b0;
    bus.i2c_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ms = 0;
        mcnt = 0;
        bus.i2c_busy = 1'b0;
        bus.i2c_done = 1'b0;
      end else begin
        if (bus.pix_ack) ack_cnt++;
        case (ms)
          0: begin
            bus.i2c_done = 1'b0;
            if (bus.i2c_start) begin
              log_q.push_back({bus.i2c_last, bus.i2c_data});
              start_cyc = cyc;
              mcnt = 0;
              ms = 1;
            end
          end
          1: begin
            mcnt++;
            if (mcnt == 2) begin
              bus.i2c_busy = 1'b1;
              mcnt = 0;
              ms = 2;
            end
          end
          default: begin
            mcnt++;
            if (mcnt == 40) begin
              bus.i2c_busy = 1'b0;
              if (!no_done) begin
                bus.i2c_done = 1'b1;
                last_done_cyc = cyc;
              end
              ms = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    int ack_cyc;
    bit early;
    init_exp = '{8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                 8'h40, 8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    // request held from reset: must wait for init
    bus.pix_req  = 1'b1;
    bus.pix_page = 3'd5;
    bus.pix_col  = 7'h12;
    bus.pix_data = 8'h3C;
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.i2c_data, bus.i2c_start, bus.i2c_last, bus.pix_ack, ready, err}, 0);
    rst_n = 1'b1;

    early = 1'b0;
    for (int i = 0; i < PWRUP; i++) begin
      @(negedge clk);
      if (bus.i2c_start) early = 1'b1;
    end
    check("pwrup_quiet", early, 0);

    wait_ready("init_ready", 3000);
    check("init_count", log_q.size(), 27);
    check("init_no_ack", ack_cnt, 0);
    check_init(0);

    wait_ack("t3_ack", 1000);
    bus.pix_req = 1'b0;
    check("t3_ready_at_ack", ready, 1);
    exp8[0:7] = '{9'h078, 9'h000, 9'h0B5, 9'h002, 9'h111, 9'h078, 9'h040, 9'h13C};
    check_pix("t3", 27, 8);
    repeat (200) @(negedge clk);
    check("t3_single_write", log_q.size(), 35);
    check("t3_ack_count", ack_cnt, 1);

    // single pixel write
    log_q.delete();
    ack_cnt = 0;
    bus.pix_page = 3'd3;
    bus.pix_col  = 7'h45;
    bus.pix_data = 8'hA5;
    bus.pix_req  = 1'b1;
    wait_ack("t2_ack", 1000);
    ack_cyc = cyc;
    bus.pix_req = 1'b0;
    check("t2_ack_latency", ack_cyc - last_done_cyc, 1);
    check("t2_ready_at_ack", ready, 1);
    exp8[0:7] = '{9'h078, 9'h000, 9'h0B3, 9'h005, 9'h114, 9'h078, 9'h040, 9'h1A5};
    check_pix("t2", 0, 8);
    @(negedge clk);
    check("t2_ack_pulse", bus.pix_ack, 0);
    check("t2_ready_after", ready, 1);

    // back-to-back requests
    log_q.delete();
    ack_cnt = 0;
    bus.pix_page = 3'd0;
    bus.pix_col  = 7'h00;
    bus.pix_data = 8'hFF;
    bus.pix_req  = 1'b1;
    wait_ack("t4_ack1", 1000);
    bus.pix_page = 3'd7;
    bus.pix_col  = 7'h7F;
    bus.pix_data = 8'h81;
    wait_ack("t4_ack2", 1000);
    bus.pix_req = 1'b0;
    exp8 = '{9'h078, 9'h000, 9'h0B0, 9'h000, 9'h110, 9'h078, 9'h040, 9'h1FF,
             9'h078, 9'h000, 9'h0B7, 9'h00F, 9'h117, 9'h078, 9'h040, 9'h181};
    check_pix("t4", 0, 16);
    repeat (100) @(negedge clk);
    check("t4_count", log_q.size(), 16);
    check("t4_acks", ack_cnt, 2);

    // reset during the third init byte
    rst_n = 1'b0;
    @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    wait_log("t6_third", 3, 1000);
    #1 rst_n = 1'b0;
    #1 check("t6_rst_outs", {bus.i2c_data, bus.i2c_start, bus.i2c_last, bus.pix_ack, ready, err}, 0);
    @(negedge clk);
    log_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("t6_ready", 3000);
    check("t6_count", log_q.size(), 27);
    check_init(0);

    // master never completes: timeout, sticky err, init restart
    no_done = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    wait_err("t5_err", 1000);
    check("t5_err_delay", cyc - start_cyc, TMO);
    check("t5_start_low", bus.i2c_start, 0);
    check("t5_first", get_log(0), 12'h078);
    wait_log("t5_restart", 2, 500);
    check("t5_restart_byte", get_log(1), 12'h078);
    repeat (150) @(negedge clk);
    check("t5_err_sticky", err, 1);
    check("t5_not_ready", ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
